// File: rtl/muldiv_seq_pkg.sv
// Shared constants and types for the iterative M-extension unit.
package muldiv_seq_pkg;

  localparam logic [2:0] FUNCT3_ALU_MUL    = 3'b000;
  localparam logic [2:0] FUNCT3_ALU_MULH   = 3'b001;
  localparam logic [2:0] FUNCT3_ALU_MULHSU = 3'b010;
  localparam logic [2:0] FUNCT3_ALU_MULHU  = 3'b011;
  localparam logic [2:0] FUNCT3_ALU_DIV    = 3'b100;
  localparam logic [2:0] FUNCT3_ALU_DIVU   = 3'b101;
  localparam logic [2:0] FUNCT3_ALU_REM    = 3'b110;
  localparam logic [2:0] FUNCT3_ALU_REMU   = 3'b111;

  typedef enum logic [1:0] {IDLE, CALC, FIXUP, DONE} muldiv_state_t;

  // Operand signedness per op; MUL low half is sign-agnostic so it runs unsigned.
  function automatic logic op_a_signed(input logic [2:0] f);
    return (f == FUNCT3_ALU_MULH) || (f == FUNCT3_ALU_MULHSU) ||
           (f == FUNCT3_ALU_DIV)  || (f == FUNCT3_ALU_REM);
  endfunction

  function automatic logic op_b_signed(input logic [2:0] f);
    return (f == FUNCT3_ALU_MULH) || (f == FUNCT3_ALU_DIV) || (f == FUNCT3_ALU_REM);
  endfunction

endpackage

// File: rtl/muldiv_fixup.sv
// Sign correction of the unsigned core result and final result select.
module muldiv_fixup
  import muldiv_seq_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [2:0]        funct3_i,
  input  logic              sign_a_i,
  input  logic              sign_b_i,
  input  logic [2*XLEN-1:0] acc_i,
  output logic [XLEN-1:0]   result_c_o
);

  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   quot;
  logic [XLEN-1:0]   rem;

  // Unsigned ops never record sign flags, so negation is a no-op for them.
  assign prod = (sign_a_i ^ sign_b_i) ? -acc_i : acc_i;
  assign quot = (sign_a_i ^ sign_b_i) ? -acc_i[XLEN-1:0] : acc_i[XLEN-1:0];
  assign rem  = sign_a_i ? -acc_i[2*XLEN-1:XLEN] : acc_i[2*XLEN-1:XLEN];

  always_comb begin
    result_c_o = '0;
    unique case (funct3_i)
      FUNCT3_ALU_MUL:                                       result_c_o = prod[XLEN-1:0];
      FUNCT3_ALU_MULH, FUNCT3_ALU_MULHSU, FUNCT3_ALU_MULHU: result_c_o = prod[2*XLEN-1:XLEN];
      FUNCT3_ALU_DIV, FUNCT3_ALU_DIVU:                      result_c_o = quot;
      default:                                              result_c_o = rem;
    endcase
  end

endmodule

// File: rtl/muldiv_seq.sv
// Iterative RV M-extension unit: radix-2 shift-add multiply, restoring divide.
module muldiv_seq
  import muldiv_seq_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      in_funct3,
  input  logic [XLEN-1:0] in_op_a,
  input  logic [XLEN-1:0] in_op_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_result,
  output logic            busy
);

  localparam int unsigned     CNT_W   = $clog2(XLEN) + 1;
  localparam logic [XLEN-1:0] MIN_INT = {1'b1, {(XLEN-1){1'b0}}};

  muldiv_state_t     state_q, state_d;
  logic [2:0]        funct3_q, funct3_d;
  logic              sign_a_q, sign_a_d, sign_b_q, sign_b_d;
  logic [XLEN-1:0]   mcand_q, mcand_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              out_valid_q, out_valid_d;
  logic [XLEN-1:0]   result_q, result_d;
  logic              in_ready_q, in_ready_d;
  logic              busy_q, busy_d;

  // Request decode: magnitudes and special cases resolved at accept.
  logic            a_neg, b_neg, div_zero, div_ovf;
  logic [XLEN-1:0] abs_a, abs_b;

  assign a_neg    = op_a_signed(in_funct3) & in_op_a[XLEN-1];
  assign b_neg    = op_b_signed(in_funct3) & in_op_b[XLEN-1];
  assign abs_a    = a_neg ? -in_op_a : in_op_a;
  assign abs_b    = b_neg ? -in_op_b : in_op_b;
  assign div_zero = in_funct3[2] && (in_op_b == '0);
  assign div_ovf  = ((in_funct3 == FUNCT3_ALU_DIV) || (in_funct3 == FUNCT3_ALU_REM)) &&
                    (in_op_a == MIN_INT) && (in_op_b == '1);

  // One iteration step; acc holds product:multiplier or remainder:quotient.
  logic [XLEN-1:0] acc_hi, acc_lo, rem_sub;
  logic [XLEN:0]   mul_sum, rem_sh;
  logic            div_fit;

  assign acc_hi  = acc_q[2*XLEN-1:XLEN];
  assign acc_lo  = acc_q[XLEN-1:0];
  assign mul_sum = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, mcand_q} : '0);
  assign rem_sh  = {acc_hi, acc_lo[XLEN-1]};
  assign div_fit = rem_sh >= {1'b0, mcand_q};
  assign rem_sub = XLEN'(rem_sh - {1'b0, mcand_q});

  logic [XLEN-1:0] fix_result;

  muldiv_fixup #(.XLEN(XLEN)) u_fixup (
    .funct3_i   (funct3_q),
    .sign_a_i   (sign_a_q),
    .sign_b_i   (sign_b_q),
    .acc_i      (acc_q),
    .result_c_o (fix_result)
  );

  always_comb begin
    state_d     = state_q;
    funct3_d    = funct3_q;
    sign_a_d    = sign_a_q;
    sign_b_d    = sign_b_q;
    mcand_d     = mcand_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    result_d    = result_q;

    unique case (state_q)
      IDLE: begin
        if (in_valid && !flush) begin
          funct3_d = in_funct3;
          sign_a_d = a_neg;
          sign_b_d = b_neg;
          cnt_d    = CNT_W'(XLEN);
          if (in_funct3[2]) begin
            acc_d   = {{XLEN{1'b0}}, abs_a};
            mcand_d = abs_b;
          end else begin
            acc_d   = {{XLEN{1'b0}}, abs_b};
            mcand_d = abs_a;
          end
          if (div_zero) begin
            state_d     = DONE;
            out_valid_d = 1'b1;
            result_d    = in_funct3[1] ? in_op_a : '1;
          end else if (div_ovf) begin
            state_d     = DONE;
            out_valid_d = 1'b1;
            result_d    = in_funct3[1] ? '0 : MIN_INT;
          end else begin
            state_d = CALC;
          end
        end
      end
      CALC: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (funct3_q[2]) begin
          acc_d = {div_fit ? rem_sub : rem_sh[XLEN-1:0], acc_lo[XLEN-2:0], div_fit};
        end else begin
          acc_d = {mul_sum, acc_lo[XLEN-1:1]};
        end
        if (cnt_q == CNT_W'(1)) state_d = FIXUP;
      end
      FIXUP: begin
        state_d     = DONE;
        out_valid_d = 1'b1;
        result_d    = fix_result;
      end
      DONE: begin
        if (out_ready) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase

    // A pipeline kill discards the op from any state, including a pending handshake.
    if (flush) begin
      state_d     = IDLE;
      out_valid_d = 1'b0;
      result_d    = result_q;
    end

    in_ready_d = (state_d == IDLE);
    busy_d     = (state_d != IDLE);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      funct3_q    <= '0;
      sign_a_q    <= 1'b0;
      sign_b_q    <= 1'b0;
      mcand_q     <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      in_ready_q  <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      funct3_q    <= funct3_d;
      sign_a_q    <= sign_a_d;
      sign_b_q    <= sign_b_d;
      mcand_q     <= mcand_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      in_ready_q  <= in_ready_d;
      busy_q      <= busy_d;
    end
  end

  assign in_ready   = in_ready_q;
  assign busy       = busy_q;
  assign out_valid  = out_valid_q;
  assign out_result = result_q;

endmodule

// File: doc/muldiv_seq.md
Name: muldiv_seq

Overview:
Iterative RV M-extension execution unit, parametrised in XLEN. It decodes funct3 into MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU and computes the result over multiple cycles: radix-2 shift-add multiply and restoring divide. Sits beside the single-cycle ALU in the execute stage. The pipeline stalls on in_ready/out_valid handshakes, so M ops no longer need a combinational multiplier/divider.

Parameters:
XLEN, 32, operand/result width; legal values ≥4, even.
CNT_W, $clog2(XLEN)+1, iteration counter width (derived, not overridden).

Ports:
clock  in  1  rising-edge clock
reset_n  in  1  asynchronous active-low reset
flush  in  1  abort current op (pipeline kill)
in_valid  in  1  request valid
in_ready  out  1  unit can accept request (high only in IDLE)
in_funct3  in  3  M-op select (000 MUL … 111 REMU, RV encoding)
in_op_a  in  XLEN  rs1 value
in_op_b  in  XLEN  rs2 value
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result
out_result  out  XLEN  result
busy  out  1  state != IDLE

Behaviour:
- Reset (async, reset_n=0): state=IDLE, out_valid=0, out_result=0, busy=0, counter=0; in_ready=1 once reset_n high. Reset mid-op discards everything immediately.
- States: IDLE, CALC, FIXUP, DONE.
- IDLE: in_ready=1. in_valid&&!flush → latch funct3, record sign flags, load |a|,|b| (signedness per op; MULHSU: a signed, b unsigned; *U ops unsigned), counter=XLEN. Next state CALC, or DONE via special case.
- Special cases, decided at accept, bypass CALC/FIXUP, out_valid the cycle after accept:
  divide by zero: DIV/DIVU → all ones; REM/REMU → in_op_a.
  signed overflow (DIV/REM, a=MIN_INT, b=-1): DIV → MIN_INT; REM → 0.
- CALC: one iteration per cycle, counter decrements. Exactly XLEN cycles, then FIXUP.
  multiply: 2*XLEN-bit product accumulator, shift-add on multiplier LSB.
  divide: shift remainder:quotient left, trial-subtract divisor, set quotient bit on non-negative.
- FIXUP (1 cycle): negate product if sign_a^sign_b (signed variants); negate quotient if sign_a^sign_b; negate remainder if sign_a. Select result: MUL low half; MULH/MULHSU/MULHU high half; DIV/DIVU quotient; REM/REMU remainder. Register into out_result. Next DONE.
- DONE: out_valid=1, out_result held stable until out_valid&&out_ready. Then IDLE next cycle, out_valid=0, out_result keeps last value.
- Latency: normal op out_valid rises XLEN+2 cycles after the accept edge (34 for XLEN=32). Special cases: 1 cycle.
- No new request accepted in DONE, even if out_ready=1 that cycle (in_ready=0).
- flush: any state → IDLE next cycle, out_valid=0, result discarded. flush with in_valid in IDLE → not accepted. flush beats out_ready in DONE: treated as discard, handshake not counted.
- All arithmetic is modulo 2^XLEN (2^(2*XLEN) for the product). Negation of MIN_INT wraps to itself, and the unsigned core handles it correctly.

Decomposition:
- Shared constants file: FUNCT3_ALU_MUL…FUNCT3_ALU_REMU (existing names), muldiv_state_t enum {IDLE, CALC, FIXUP, DONE}.
- One natural combinational sub-module: muldiv_fixup (sign correction + result select, XLEN-parametrised).
- FSM, counter and datapath registers stay in muldiv_seq.

Test Plan:
- MUL a=7, b=0xFFFFFFFD (-3) → out_result 0xFFFFFFEB, out_valid exactly 34 cycles after accept, in_ready low throughout.
- MULH 0x80000000×0x80000000 → 0x40000000; MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE; MULHSU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFF.
- DIV 0xFFFFFFF9÷2 → 0xFFFFFFFD; REM same → 0xFFFFFFFF; DIVU 100÷7 → 14; REMU 100÷7 → 2.
- Special cases: DIV 5÷0 → 0xFFFFFFFF; REMU 5÷0 → 5; DIV 0x80000000÷0xFFFFFFFF → 0x80000000; REM same → 0. Each with out_valid 1 cycle after accept.
- Backpressure: out_ready=0 for 5 cycles in DONE → out_result/out_valid stable, in_ready=0. out_ready=1 → IDLE next cycle, a back-to-back request is then accepted.
- flush at CALC cycle 10 → out_valid never rises, in_ready=1 next cycle. reset_n pulsed low mid-CALC → busy/out_valid=0 asynchronously, a following MUL 3×4 → 12.
